// File: rtl/modexp_sequencer_if.sv
// Bundle of the sequencer's handshake and data buses: command port, BRAM
// operand/result ports, multiplier core port and status handshake.
// slave = the sequencer's view, master = the surrounding system's view.
interface modexp_sequencer_if #(
   parameter int WIDTH = 512
) ();
   logic [31:0]      cmd_data;
   logic             cmd_valid;
   logic             cmd_read;
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic [WIDTH-1:0] mul_n;
   logic             mul_start;
   logic             mul_done;
   logic [WIDTH-1:0] mul_result;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_read;
   logic             status_valid;
   logic             status_read;
   logic             busy;

   modport slave (
      input  cmd_data, cmd_valid, din, din_valid, mul_done, mul_result,
             dout_read, status_read,
      output cmd_read, mul_a, mul_b, mul_n, mul_start, dout, dout_valid,
             status_valid, busy
   );

   modport master (
      output cmd_data, cmd_valid, din, din_valid, mul_done, mul_result,
             dout_read, status_read,
      input  cmd_read, mul_a, mul_b, mul_n, mul_start, dout, dout_valid,
             status_valid, busy
   );
endinterface

// File: rtl/modexp_sequencer.sv
// Left-to-right square-and-multiply modular exponentiation controller driving
// one shared Montgomery multiplier, one product outstanding at a time.
// Optional macro MODEXP_SEQUENCER_FINAL_CONV_EN: adds a final MontMul(A,1)
// to bring the result out of the Montgomery domain before it is returned.
module modexp_sequencer #(
   parameter int WIDTH    = 512,
   parameter int LEN_BITS = 16
) (
   input logic            clk,
   input logic            reset,
   modexp_sequencer_if.slave bus
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [LEN_BITS-1:0] WIDTH_L = LEN_BITS'(WIDTH);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_SQ_START,
      S_SQ_WAIT,
      S_MUL_START,
      S_MUL_WAIT,
      S_NEXT,
`ifdef MODEXP_SEQUENCER_FINAL_CONV_EN
      S_CONV_START,
      S_CONV_WAIT,
`endif
      S_FINISH,
      S_OUT,
      S_STAT
   } state_t;

   // Where the exponent loop exits to: the domain conversion when enabled.
`ifdef MODEXP_SEQUENCER_FINAL_CONV_EN
   localparam state_t S_LOOP_EXIT = S_CONV_START;
`else
   localparam state_t S_LOOP_EXIT = S_FINISH;
`endif

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   n_q, n_d;
   logic [WIDTH-1:0]   e_q, e_d;
   logic [WIDTH-1:0]   x_q, x_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [LEN_BITS-1:0] len_q, len_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [1:0]         ld_cnt_q, ld_cnt_d;
   logic               cmd_read_q, cmd_read_d;
   logic [WIDTH-1:0]   mul_a_q, mul_a_d;
   logic [WIDTH-1:0]   mul_b_q, mul_b_d;
   logic               mul_start_q, mul_start_d;
   logic [WIDTH-1:0]   dout_q, dout_d;
   logic               dout_valid_q, dout_valid_d;
   logic               status_valid_q, status_valid_d;
   logic [LEN_BITS-1:0] cmd_len;

   // Command length with anything beyond the operand width clamped to it.
   assign cmd_len = (bus.cmd_data[LEN_BITS-1:0] > WIDTH_L) ? WIDTH_L
                                                          : bus.cmd_data[LEN_BITS-1:0];

   generate
      if (LEN_BITS < 32) begin : g_cmd_hi
         logic unused_cmd_hi;
         assign unused_cmd_hi = ^bus.cmd_data[31:LEN_BITS];
      end
   endgenerate

   // Next-state and datapath: pulses default low, everything else holds.
   always_comb begin
      state_d        = state_q;
      n_d            = n_q;
      e_d            = e_q;
      x_d            = x_q;
      a_d            = a_q;
      len_d          = len_q;
      idx_d          = idx_q;
      ld_cnt_d       = ld_cnt_q;
      cmd_read_d     = 1'b0;
      mul_a_d        = mul_a_q;
      mul_b_d        = mul_b_q;
      mul_start_d    = 1'b0;
      dout_d         = dout_q;
      dout_valid_d   = dout_valid_q;
      status_valid_d = status_valid_q;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               len_d      = cmd_len;
               cmd_read_d = 1'b1;
               ld_cnt_d   = 2'd0;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            if (bus.din_valid) begin
               case (ld_cnt_q)
                  2'd0:    n_d = bus.din;
                  2'd1:    e_d = bus.din;
                  2'd2:    x_d = bus.din;
                  default: a_d = bus.din;
               endcase
               ld_cnt_d = ld_cnt_q + 2'd1;
               if (ld_cnt_q == 2'd3) begin
                  idx_d   = IW'(len_q - LEN_BITS'(1));
                  state_d = (len_q == '0) ? S_LOOP_EXIT : S_SQ_START;
               end
            end
         end
         S_SQ_START: begin
            mul_a_d     = a_q;
            mul_b_d     = a_q;
            mul_start_d = 1'b1;
            state_d     = S_SQ_WAIT;
         end
         S_SQ_WAIT: begin
            if (bus.mul_done) begin
               a_d     = bus.mul_result;
               state_d = e_q[idx_q] ? S_MUL_START : S_NEXT;
            end
         end
         S_MUL_START: begin
            mul_a_d     = a_q;
            mul_b_d     = x_q;
            mul_start_d = 1'b1;
            state_d     = S_MUL_WAIT;
         end
         S_MUL_WAIT: begin
            if (bus.mul_done) begin
               a_d     = bus.mul_result;
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (idx_q == '0) begin
               state_d = S_LOOP_EXIT;
            end else begin
               idx_d   = idx_q - IW'(1);
               state_d = S_SQ_START;
            end
         end
`ifdef MODEXP_SEQUENCER_FINAL_CONV_EN
         S_CONV_START: begin
            mul_a_d     = a_q;
            mul_b_d     = WIDTH'(1);
            mul_start_d = 1'b1;
            state_d     = S_CONV_WAIT;
         end
         S_CONV_WAIT: begin
            if (bus.mul_done) begin
               a_d     = bus.mul_result;
               state_d = S_FINISH;
            end
         end
`endif
         S_FINISH: begin
            dout_d       = a_q;
            dout_valid_d = 1'b1;
            state_d      = S_OUT;
         end
         S_OUT: begin
            if (bus.dout_read) begin
               dout_valid_d   = 1'b0;
               status_valid_d = 1'b1;
               state_d        = S_STAT;
            end
         end
         S_STAT: begin
            if (bus.status_read) begin
               status_valid_d = 1'b0;
               state_d        = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation immediately.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         n_q            <= '0;
         e_q            <= '0;
         x_q            <= '0;
         a_q            <= '0;
         len_q          <= '0;
         idx_q          <= '0;
         ld_cnt_q       <= '0;
         cmd_read_q     <= 1'b0;
         mul_a_q        <= '0;
         mul_b_q        <= '0;
         mul_start_q    <= 1'b0;
         dout_q         <= '0;
         dout_valid_q   <= 1'b0;
         status_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         n_q            <= n_d;
         e_q            <= e_d;
         x_q            <= x_d;
         a_q            <= a_d;
         len_q          <= len_d;
         idx_q          <= idx_d;
         ld_cnt_q       <= ld_cnt_d;
         cmd_read_q     <= cmd_read_d;
         mul_a_q        <= mul_a_d;
         mul_b_q        <= mul_b_d;
         mul_start_q    <= mul_start_d;
         dout_q         <= dout_d;
         dout_valid_q   <= dout_valid_d;
         status_valid_q <= status_valid_d;
      end
   end

   // The modulus register feeds the multiplier directly; it only changes in LOAD.
   assign bus.cmd_read     = cmd_read_q;
   assign bus.mul_a        = mul_a_q;
   assign bus.mul_b        = mul_b_q;
   assign bus.mul_n        = n_q;
   assign bus.mul_start    = mul_start_q;
   assign bus.dout         = dout_q;
   assign bus.dout_valid   = dout_valid_q;
   assign bus.status_valid = status_valid_q;
   assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: doc/modexp_sequencer.md
Name: modexp_sequencer

Overview:
- Controller that runs a left-to-right square-and-multiply modular exponentiation on one shared Montgomery multiplier core.
- Accepts a 32-bit command word on the port1-style handshake and takes operands as WIDTH-bit words from the BRAM-side parallel read port (doutb/doutb_valid).
- Issues one Montgomery product at a time and returns the result on the BRAM write-back port (dinb/web/dinb_read).
- Signals completion on the port2-style valid/read handshake.

Parameters:
- WIDTH, 512, operand/modulus width in bits (NUM_OF_CORES*512 at integration).
- LEN_BITS, 16, width of exponent-length field in the command word.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_data  in  32  command; [LEN_BITS-1:0] = exponent bit length L.
- cmd_valid  in  1  command present.
- cmd_read  out  1  one-cycle pulse; command consumed.
- din  in  WIDTH  operand word from BRAM.
- din_valid  in  1  one-cycle strobe; din valid.
- mul_a  out  WIDTH  multiplier operand A.
- mul_b  out  WIDTH  multiplier operand B.
- mul_n  out  WIDTH  modulus to multiplier.
- mul_start  out  1  one-cycle start pulse.
- mul_done  in  1  one-cycle strobe; mul_result valid.
- mul_result  in  WIDTH  Montgomery product.
- dout  out  WIDTH  final result.
- dout_valid  out  1  result present; held until dout_read.
- dout_read  in  1  result consumed.
- status_valid  out  1  operation complete; held until status_read.
- status_read  in  1  status consumed.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0; all registers (N, E, X, A, L, i, load count) cleared; state IDLE. Reset mid-operation aborts at once. Any later mul_done is ignored until a new WAIT state.
- IDLE: when cmd_valid=1, latch L and pulse cmd_read in the next cycle, then go to LOAD. cmd_valid while busy is not acknowledged.
- Length clamp: L>WIDTH is clamped to WIDTH.
- LOAD: accept 4 din_valid strobes in fixed order: N, E, X (base, Montgomery domain), A (R mod N). 2-bit counter; din_valid outside LOAD is ignored.
- After the 4th strobe: i=L-1, go to SQ_START. If L=0, go directly to FINISH.
- SQ_START: mul_a=mul_b=A; pulse mul_start; go to SQ_WAIT.
- SQ_WAIT: on mul_done, A<=mul_result. If E[i]=1 go to MUL_START, else go to NEXT.
- MUL_START: mul_a=A, mul_b=X; pulse mul_start; go to MUL_WAIT.
- MUL_WAIT: on mul_done, A<=mul_result; go to NEXT.
- NEXT: if i==0 go to FINISH; else i<=i-1 and go to SQ_START.
- Operand stability: mul_a, mul_b and mul_n are registered and stay stable from mul_start until mul_done. Exactly one product is outstanding at a time.
- FINISH: dout<=A, dout_valid=1; go to OUT.
- OUT: hold until dout_read=1. Then dout_valid=0, status_valid=1; go to STAT.
- STAT: hold until status_read=1. Then status_valid=0; go to IDLE.
- Same-cycle read: dout_read asserted in the same cycle dout_valid rises is honoured.
- Multiplier usage: L squarings plus popcount(E[L-1:0]) multiplications. Controller overhead is 2 cycles per product (START plus the mul_done cycle) plus 1 cycle per NEXT.

Optional Feature:
- Macro: MODEXP_SEQUENCER_FINAL_CONV_EN.
- Defined: FINISH is preceded by CONV_START/CONV_WAIT, which computes A<=MontMul(A,1) (mul_b = WIDTH'd1) to leave the Montgomery domain. This costs one extra mul_start per operation, including when L=0.
- Undefined: the result is returned in the Montgomery domain; the states are absent.

Test Plan:
- Bench multiplier model is plain (a*b) mod n with latency 5.
- Basic exponentiation: cmd L=4; din N=23, E=11, X=5, A=1 -> exactly 7 mul_start pulses (8 with the feature), dout=22, dout_valid held until dout_read, then status_valid.
- Zero length: L=0, A=1 -> no mul_start (1 with the feature), dout=1.
- Length clamp: L=WIDTH+5 with E=1 -> treated as L=WIDTH; 513 mul_start pulses for WIDTH=512; dout=X mod N.
- Ignored inputs: cmd_valid held during an operation gives no second cmd_read. A din_valid in IDLE changes nothing. A spurious mul_done in SQ_START is ignored. Result is still 22 for the basic case.
- Back-pressure: dout_read delayed 10 cycles and status_read delayed 7 -> outputs held stable; busy stays high until status_read is accepted.
- Reset mid-operation: reset asserted during MUL_WAIT -> next cycle all outputs 0 and state IDLE. A following fresh run of the basic case gives 22.
